// File: rtl/bcd_key_accumulator.sv
// Registered decimal-key to BCD accumulator: encodes debounced key presses into
// a packed BCD number and commits it downstream over a valid/ready handshake.
module bcd_key_accumulator #(
   parameter int DIGITS         = 4,
   parameter int MODE           = 0,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [9:0]                   key_in,
   input  logic                         clear,
   input  logic                         enter,
   output logic [4*DIGITS-1:0]          acc_out,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count,
   output logic                         full,
   output logic                         err,
   output logic [4*DIGITS-1:0]          bcd_out,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int AW = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam int RW = $clog2(RELEASE_CYCLES + 1);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DIGITS);
   localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HELD = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   logic [1:0]    state;
   logic [RW-1:0] rel_cnt;
   logic [3:0]    digit;
   logic          one_hot;
   logic          key_valid;
   logic          key_any;

   // Ascending scan leaves the highest set index in digit; strict mode only
   // trusts it when exactly one line is asserted.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      digit = 4'd0;
      for (int k = 0; k < 10; k++) begin
         if (key_in[k]) digit = 4'(k);
      end
      key_any   = (key_in != 10'd0);
      one_hot   = key_any && ((key_in & (key_in - 10'd1)) == 10'd0);
      key_valid = (MODE == 1) ? key_any : one_hot;
   end

   assign full = (digit_count == FULL_COUNT);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rel_cnt     <= '0;
         acc_out     <= '0;
         digit_count <= '0;
         err         <= 1'b0;
         bcd_out     <= '0;
         out_valid   <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE, HELD: begin
               if (clear) begin
                  acc_out     <= '0;
                  digit_count <= '0;
               end else if (enter) begin
                  if (digit_count != '0) begin
                     bcd_out     <= acc_out;
                     out_valid   <= 1'b1;
                     acc_out     <= '0;
                     digit_count <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end else if (state == IDLE && key_any) begin
                  if (key_valid && !full) begin
                     acc_out     <= (acc_out << 4) | AW'(digit);
                     digit_count <= digit_count + 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end

               // State/release bookkeeping; a successful commit overrides it.
               if (!clear && enter && digit_count != '0) begin
                  state   <= OUT;
                  rel_cnt <= '0;
               end else if (state == IDLE) begin
                  if (!clear && !enter && key_any) begin
                     state   <= HELD;
                     rel_cnt <= '0;
                  end
               end else if (key_any) begin
                  rel_cnt <= '0;
               end else if (rel_cnt == REL_LAST) begin
                  state   <= IDLE;
                  rel_cnt <= '0;
               end else begin
                  rel_cnt <= rel_cnt + 1'b1;
               end
            end
            OUT: begin
               // Inputs are ignored until the consumer takes the number; the
               // return through HELD forces a fresh release window.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= HELD;
                  rel_cnt   <= '0;
               end
            end
            default: begin
               state   <= IDLE;
               rel_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/bcd_key_accumulator.md
# bcd_key_accumulator

Parametrised, registered successor to the combinational decimal-to-BCD encoder. It samples ten decimal key lines and encodes each accepted press into a 4-bit BCD digit. Digits shift into a DIGITS-wide packed BCD accumulator, and the accumulated number is committed to a downstream consumer over a valid/ready handshake. It sits between keypad/switch front-end logic and numeric datapath or display blocks.

## Interface
Parameters:
- DIGITS, 4: accumulator depth in BCD digits (>= 1).
- MODE, 0: 0 = strict one-hot (multi-hot rejected); 1 = priority (highest asserted index wins).
- RELEASE_CYCLES, 4: consecutive all-zero key cycles required before the next press is accepted (>= 1).

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  10  decimal key lines; bit k = digit k; synchronous to clk.
- clear  input  1  discard accumulated digits.
- enter  input  1  commit accumulated number.
- acc_out  output  4*DIGITS  live accumulator; most recent digit in bits [3:0].
- digit_count  output  $clog2(DIGITS+1)  number of digits held.
- full  output  1  digit_count == DIGITS.
- err  output  1  one-cycle error pulse.
- bcd_out  output  4*DIGITS  committed number.
- out_valid  output  1  bcd_out valid.
- out_ready  input  1  consumer accepts bcd_out.

## Operation
FSM states: IDLE, HELD, OUT.

- Reset (async): state = IDLE; acc_out, bcd_out, digit_count, release counter = 0; full, err, out_valid = 0.
- Encoding:
  - MODE=0: valid only if key_in is one-hot.
  - MODE=1: any nonzero key_in is valid; digit = highest set index.
- Per-cycle priority in IDLE/HELD: clear > enter > key.
- clear:
  - acc_out = 0, digit_count = 0.
  - State unchanged; err not asserted.
- enter:
  - If digit_count > 0: bcd_out <= acc_out, out_valid <= 1, acc_out/digit_count <= 0, state -> OUT. A key sampled in the same cycle is ignored.
  - If digit_count == 0: err pulse; no other effect.
- Key in IDLE with key_in != 0 (no clear/enter), state -> HELD in all cases:
  - Valid encoding, not full: acc_out <= {acc_out[4*DIGITS-5:0], digit}; digit_count++.
  - Valid encoding, full: err pulse; digit dropped.
  - Invalid encoding (MODE=0 multi-hot): err pulse; accumulator unchanged.
- HELD:
  - key_in ignored for encoding.
  - Release counter increments on each key_in == 0 cycle and resets to 0 on any nonzero cycle.
  - Reaching RELEASE_CYCLES -> IDLE, counter cleared. This debounces bounce and auto-repeat.
- OUT:
  - key_in, clear and enter are ignored; bcd_out and out_valid are held stable.
  - Transfer on out_valid && out_ready; next cycle out_valid = 0 and state -> HELD (forces a release window).
- bcd_out retains its last committed value after transfer.
- err is never asserted while in OUT.

## Timing
- Key accepted at edge N: acc_out/digit_count/full update at edge N (visible cycle N+1); err likewise one cycle wide.
- enter at edge N: out_valid high from N+1. With out_ready constantly high, out_valid is exactly one cycle.
- Minimum spacing between two accepted presses: 1 press cycle + RELEASE_CYCLES zero cycles.
- Asynchronous reset mid-operation clears everything immediately, including a pending out_valid.
- No combinational path from inputs to outputs; all outputs registered.

## Test plan
- Digit entry (DIGITS=4, MODE=0, RELEASE_CYCLES=4):
  - Stimulus: press 0x002 for 3 cycles, release 4; press 0x200, release 4; press 0x020, release 4; enter with out_ready=1.
  - Required: acc_out 0x0001 -> 0x0019 -> 0x0195; then bcd_out = 0x0195, out_valid high 1 cycle, digit_count = 0.
- Invalid/priority:
  - MODE=0: key_in = 0x006 -> err 1 cycle, acc_out unchanged.
  - MODE=1, same stimulus -> digit 2 appended, no err.
- Overflow:
  - Stimulus: enter 1, 2, 3, 4, then 5.
  - Required: full after 4th digit, acc_out = 0x1234; 5th press -> err pulse, acc_out stays 0x1234.
- Debounce:
  - Stimulus: press 0x080, zero 2 cycles, 0x080 again, zero 4 cycles.
  - Required: exactly one digit 7 appended; digit_count = 1.
- Backpressure / clear:
  - Stimulus: enter with out_ready=0 for 5 cycles, toggling keys and clear meanwhile; then out_ready=1.
  - Required: out_valid and bcd_out stable, acc_out stays 0; out_valid drops the cycle after transfer. Clear with enter in same cycle -> acc cleared, no commit. Enter with empty acc -> err only.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously (between clock edges) while out_valid=1 and acc_out = 0x0042.
  - Required: out_valid, acc_out, digit_count, bcd_out = 0 immediately; IDLE accepts a press the first cycle after release.
